// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR power-up initialization sequencer:
// command encodings, sequencer states and mode-register bit positions.
`timescale 1ns/1ps
package ddr_pkg;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP       = 3'b111;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_LOAD_MODE = 3'b000;

  localparam int DLL_RESET_BIT     = 8;
  localparam int PRECHARGE_ALL_BIT = 10;

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_WAIT_PWR,
    S_CKE_UP,
    S_PRE1,
    S_EMR,
    S_MR_DLL,
    S_PRE2,
    S_REF1,
    S_REF2,
    S_MR,
    S_DONE
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous level signal.
`timescale 1ns/1ps
module bit_synchronizer (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ddr_init_sequencer.sv
// JEDEC DDR power-up sequencer: waits for clock lock, holds CKE low, then issues
// PRE / EMR / MR(DLL reset) / PRE / REF / REF / MR and raises init_done.
`timescale 1ns/1ps
module ddr_init_sequencer
  import ddr_pkg::*;
#(
  parameter int          POWERUP_CYCLES  = 20000,
  parameter int          TRP             = 3,
  parameter int          TMRD            = 2,
  parameter int          TRFC            = 8,
  parameter int          DLL_LOCK_CYCLES = 200,
  parameter logic [12:0] MR_VALUE        = 13'h0021,
  parameter logic [12:0] EMR_VALUE       = 13'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_ok,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        init_done
);

  localparam int MAX_CNT = max2(max2(POWERUP_CYCLES, DLL_LOCK_CYCLES),
                                max2(max2(TRP, TMRD), TRFC));
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  // Each state is held for (load + 1) cycles, so loads are gap - 1.
  localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_CKE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] LD_TMRD = CNT_W'(TMRD - 1);
  localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'(TRFC - 1);
  localparam logic [CNT_W-1:0] LD_DLL  = CNT_W'(DLL_LOCK_CYCLES - 1);

  logic             w_ok_s;
  seq_state_t       r_state;
  seq_state_t       w_nxt_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt_cnt;

  logic             w_cke;
  logic             w_cs_n;
  logic [2:0]       w_cmd;
  logic [1:0]       w_ba;
  logic [12:0]      w_addr;
  logic             w_done;
  logic [12:0]      w_mr_dll;
  logic [12:0]      w_mr_run;

  logic             r_cke;
  logic             r_cs_n;
  logic [2:0]       r_cmd;
  logic [1:0]       r_ba;
  logic [12:0]      r_addr;
  logic             r_done;

  bit_synchronizer u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (clk_ok),
    .o_q     (w_ok_s)
  );

  always_comb begin
    w_mr_dll                = MR_VALUE;
    w_mr_dll[DLL_RESET_BIT] = 1'b1;
    w_mr_run                = MR_VALUE;
    w_mr_run[DLL_RESET_BIT] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_WAIT_LOCK: begin
        if (w_ok_s) begin
          w_nxt_state = S_WAIT_PWR;
          w_nxt_cnt   = LD_PWR;
        end
      end
      S_DONE: ;
      default: begin
        if (r_cnt != '0) begin
          w_nxt_cnt = r_cnt - 1'b1;
        end else begin
          case (r_state)
            S_WAIT_PWR: begin w_nxt_state = S_CKE_UP; w_nxt_cnt = LD_CKE;  end
            S_CKE_UP:   begin w_nxt_state = S_PRE1;   w_nxt_cnt = LD_TRP;  end
            S_PRE1:     begin w_nxt_state = S_EMR;    w_nxt_cnt = LD_TMRD; end
            S_EMR:      begin w_nxt_state = S_MR_DLL; w_nxt_cnt = LD_TMRD; end
            S_MR_DLL:   begin w_nxt_state = S_PRE2;   w_nxt_cnt = LD_TRP;  end
            S_PRE2:     begin w_nxt_state = S_REF1;   w_nxt_cnt = LD_TRFC; end
            S_REF1:     begin w_nxt_state = S_REF2;   w_nxt_cnt = LD_TRFC; end
            S_REF2:     begin w_nxt_state = S_MR;     w_nxt_cnt = LD_DLL;  end
            S_MR:       begin w_nxt_state = S_DONE;   w_nxt_cnt = '0;      end
            default: ;
          endcase
        end
      end
    endcase
    // Lock loss overrides everything and restarts the whole sequence.
    if (!w_ok_s && (r_state != S_WAIT_LOCK)) begin
      w_nxt_state = S_WAIT_LOCK;
      w_nxt_cnt   = '0;
    end
  end

  // Outputs are computed for the upcoming state so they change with it on the same edge;
  // a command goes out only on the first cycle of its state.
  always_comb begin
    w_cke  = 1'b0;
    w_cs_n = 1'b1;
    w_cmd  = CMD_NOP;
    w_ba   = '0;
    w_addr = '0;
    w_done = 1'b0;
    if ((w_nxt_state != S_WAIT_LOCK) && (w_nxt_state != S_WAIT_PWR)) begin
      w_cke  = 1'b1;
      w_cs_n = 1'b0;
    end
    if (w_nxt_state == S_DONE) begin
      w_done = 1'b1;
    end
    if (w_nxt_state != r_state) begin
      case (w_nxt_state)
        S_PRE1, S_PRE2: begin
          w_cmd                    = CMD_PRECHARGE;
          w_addr[PRECHARGE_ALL_BIT] = 1'b1;
        end
        S_EMR: begin
          w_cmd  = CMD_LOAD_MODE;
          w_ba   = 2'b01;
          w_addr = EMR_VALUE;
        end
        S_MR_DLL: begin
          w_cmd  = CMD_LOAD_MODE;
          w_addr = w_mr_dll;
        end
        S_REF1, S_REF2: begin
          w_cmd = CMD_REFRESH;
        end
        S_MR: begin
          w_cmd  = CMD_LOAD_MODE;
          w_addr = w_mr_run;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cke  <= 1'b0;
      r_cs_n <= 1'b1;
      r_cmd  <= CMD_NOP;
      r_ba   <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
    end else begin
      r_cke  <= w_cke;
      r_cs_n <= w_cs_n;
      r_cmd  <= w_cmd;
      r_ba   <= w_ba;
      r_addr <= w_addr;
      r_done <= w_done;
    end
  end

  assign cke                 = r_cke;
  assign cs_n                = r_cs_n;
  assign {ras_n, cas_n, we_n} = r_cmd;
  assign ba                  = r_ba;
  assign addr                = r_addr;
  assign init_done           = r_done;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Scoreboard bench for ddr_init_sequencer: expected bus events are queued when
// stimulus is applied and matched against events seen on the SDRAM bus.
`timescale 1ns/1ps
module tb_ddr_init_sequencer;

  logic        clk = 1'b0;
  logic        rst_n_a, clk_ok_a, rst_n_b, clk_ok_b;
  logic        cke_a, cs_n_a, ras_n_a, cas_n_a, we_n_a, done_a;
  logic [1:0]  ba_a;
  logic [12:0] addr_a;
  logic        cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b, done_b;
  logic [1:0]  ba_b;
  logic [12:0] addr_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          dut;
    int          cyc;
    int          kind;   // 0: cke rise, 1: command, 2: init_done rise
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } ev_t;

  ev_t        sb_q[$];
  logic [1:0] prev_cke  = 2'b00;
  logic [1:0] prev_done = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_init_sequencer #(
    .POWERUP_CYCLES (16)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n_a),
    .clk_ok    (clk_ok_a),
    .cke       (cke_a),
    .cs_n      (cs_n_a),
    .ras_n     (ras_n_a),
    .cas_n     (cas_n_a),
    .we_n      (we_n_a),
    .ba        (ba_a),
    .addr      (addr_a),
    .init_done (done_a)
  );

  ddr_init_sequencer #(
    .POWERUP_CYCLES  (4),
    .TRP             (1),
    .TMRD            (1),
    .TRFC            (1),
    .DLL_LOCK_CYCLES (1)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .clk_ok    (clk_ok_b),
    .cke       (cke_b),
    .cs_n      (cs_n_b),
    .ras_n     (ras_n_b),
    .cas_n     (cas_n_b),
    .we_n      (we_n_b),
    .ba        (ba_b),
    .addr      (addr_b),
    .init_done (done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input int d, input int t, input int k,
                         input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    ev_t e;
    e.dut = d; e.cyc = t; e.kind = k; e.cmd = c; e.ba = b; e.addr = a;
    sb_q.push_back(e);
  endtask

  // Expected bus activity for one full sequence, given the cycle cke rises.
  task automatic push_seq(input int d, input int t0, input int trp, input int tmrd,
                          input int trfc, input int dll);
    int t;
    t = t0;
    sb_push(d, t, 0, 3'b111, 2'b00, 13'h0000);
    t = t + 2;    sb_push(d, t, 1, 3'b010, 2'b00, 13'h0400);
    t = t + trp;  sb_push(d, t, 1, 3'b000, 2'b01, 13'h0000);
    t = t + tmrd; sb_push(d, t, 1, 3'b000, 2'b00, 13'h0121);
    t = t + tmrd; sb_push(d, t, 1, 3'b010, 2'b00, 13'h0400);
    t = t + trp;  sb_push(d, t, 1, 3'b001, 2'b00, 13'h0000);
    t = t + trfc; sb_push(d, t, 1, 3'b001, 2'b00, 13'h0000);
    t = t + trfc; sb_push(d, t, 1, 3'b000, 2'b00, 13'h0021);
    t = t + dll;  sb_push(d, t, 2, 3'b111, 2'b00, 13'h0000);
  endtask

  task automatic sb_observe(input int d, input int k, input logic [2:0] c,
                            input logic [1:0] b, input logic [12:0] a);
    ev_t e;
    if (sb_q.size() == 0) begin
      check_eq($sformatf("unexpected_event_dut%0d", d), 32'(k), 32'hFFFF_FFFF);
      return;
    end
    e = sb_q.pop_front();
    check_eq("ev_dut",   32'(d), 32'(e.dut));
    check_eq("ev_kind",  32'(k), 32'(e.kind));
    check_eq("ev_cycle", 32'(cyc), 32'(e.cyc));
    check_eq("ev_cmd",   32'(c), 32'(e.cmd));
    check_eq("ev_ba",    32'(b), 32'(e.ba));
    check_eq("ev_addr",  32'(a), 32'(e.addr));
  endtask

  task automatic mon_dut(input int d, input logic c, input logic cs, input logic [2:0] cm,
                         input logic [1:0] b, input logic [12:0] a, input logic dn);
    if (c && !prev_cke[d]) sb_observe(d, 0, 3'b111, 2'b00, 13'h0000);
    if (!cs && (cm != 3'b111)) begin
      sb_observe(d, 1, cm, b, a);
    end else if (!cs) begin
      check_eq("nop_ba",   32'(b), 32'd0);
      check_eq("nop_addr", 32'(a), 32'd0);
    end
    if (dn && !prev_done[d]) sb_observe(d, 2, 3'b111, 2'b00, 13'h0000);
    prev_cke[d]  = c;
    prev_done[d] = dn;
  endtask

  always begin
    @(posedge clk);
    #2;
    mon_dut(0, cke_a, cs_n_a, {ras_n_a, cas_n_a, we_n_a}, ba_a, addr_a, done_a);
    mon_dut(1, cke_b, cs_n_b, {ras_n_b, cas_n_b, we_n_b}, ba_b, addr_b, done_b);
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, "_cke"},  32'(cke_a), 32'd0);
    check_eq({tag, "_cs_n"}, 32'(cs_n_a), 32'd1);
    check_eq({tag, "_cmd"},  32'({ras_n_a, cas_n_a, we_n_a}), 32'h7);
    check_eq({tag, "_ba"},   32'(ba_a), 32'd0);
    check_eq({tag, "_addr"}, 32'(addr_a), 32'd0);
    check_eq({tag, "_done"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t0, t1, t2, bad, x;
    rst_n_a = 1'b0; clk_ok_a = 1'b0;
    rst_n_b = 1'b0; clk_ok_b = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_a("reset_a");
    check_eq("reset_b_cke",  32'(cke_b),  32'd0);
    check_eq("reset_b_cs_n", 32'(cs_n_b), 32'd1);
    check_eq("reset_b_done", 32'(done_b), 32'd0);

    // Minimum gaps: seven back-to-back commands, init_done on the next cycle.
    rel = cyc;
    rst_n_b = 1'b1;
    push_seq(1, rel + 7, 1, 1, 1, 1);
    wait_cyc(rel + 7 + 9 + 5);
    check_eq("b_done_held", 32'(done_b), 32'd1);
    check_eq("b_sb_drained", 32'(sb_q.size()), 32'd0);

    // No lock: block must stay idle.
    rst_n_a = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cke_a !== 1'b0 || cs_n_a !== 1'b1 || done_a !== 1'b0) bad++;
    end
    check_eq("nolock_bad_cycles", 32'(bad), 32'd0);

    // Reset with lock present throughout.
    rst_n_a = 1'b0;
    @(negedge clk);
    clk_ok_a = 1'b1;
    @(negedge clk);
    rel = cyc;
    rst_n_a = 1'b1;
    t0 = rel + 19;
    push_seq(0, t0, 3, 2, 8, 200);

    // One-cycle lock glitch at t0+10: REF1 still issues, then back to WAIT_LOCK.
    wait_cyc(t0 + 10);
    clk_ok_a = 1'b0;
    @(negedge clk);
    clk_ok_a = 1'b1;
    t1 = cyc + 19;
    wait_cyc(t0 + 13);
    check_idle_a("drop");
    check_eq("drop_pending", 32'(sb_q.size()), 32'd3);
    sb_q.delete();
    push_seq(0, t1, 3, 2, 8, 200);

    // Asynchronous reset mid-cycle between REF1 and REF2.
    wait_cyc(t1 + 15);
    #1 rst_n_a = 1'b0;
    #1 check_idle_a("async_rst");
    check_eq("rst_pending", 32'(sb_q.size()), 32'd3);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rel = cyc;
    rst_n_a = 1'b1;
    t2 = rel + 19;
    push_seq(0, t2, 3, 2, 8, 200);
    wait_cyc(t2 + 228 + 20);
    check_eq("done_sticky", 32'(done_a), 32'd1);
    check_eq("done_cke",    32'(cke_a),  32'd1);

    // Lock loss while done drops init_done.
    clk_ok_a = 1'b0;
    x = cyc;
    wait_cyc(x + 3);
    check_idle_a("lost_lock_done");
    repeat (5) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_init_sequencer.md
# ddr_init_sequencer

Power-up initialization sequencer for the DDR SDRAM. It sits directly downstream of the clock manager, in the 100 MHz DDR clock domain. It waits for the clock manager's lock indication, then drives the JEDEC DDR power-up command sequence onto the SDRAM command bus. It asserts `init_done` once the memory may accept normal traffic, and the DDR controller only takes over the command bus after that point.

## Interface
Parameters:
- `POWERUP_CYCLES`, 20000, cycles with CKE low after lock (200 us at 100 MHz)
- `TRP`, 3, cycles from PRECHARGE to the next command
- `TMRD`, 2, cycles from LOAD MODE to the next command
- `TRFC`, 8, cycles from AUTO REFRESH to the next command
- `DLL_LOCK_CYCLES`, 200, cycles from the final LOAD MODE to `init_done`
- `MR_VALUE`, 13'h0021, base mode register value (CL2, BL2, sequential); bit 8 (DLL reset) is always forced by this block
- `EMR_VALUE`, 13'h0000, extended mode register value (DLL enabled, normal drive)

Ports:
- `clk` in 1: DDR clock (0° phase). One clock only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_ok` in 1: DCM lock from the clock manager. It is asynchronous to `clk` and is synchronized internally.
- `cke` out 1: SDRAM clock enable
- `cs_n`, `ras_n`, `cas_n`, `we_n` out 1 each: SDRAM command
- `ba` out 2: bank address
- `addr` out 13: row/mode address
- `init_done` out 1: sequence complete

## Operation
- All outputs are registered.
- Reset values: `cke`=0, `cs_n`=1, `{ras_n,cas_n,we_n}`=111, `ba`=0, `addr`=0, `init_done`=0, state=WAIT_LOCK, counter=0.
- `clk_ok` passes through a 2-flop synchronizer; the result is `ok_s`.
- Command encodings `{ras_n,cas_n,we_n}`:
  - NOP = 111
  - PRECHARGE = 010
  - AUTO REFRESH = 001
  - LOAD MODE = 000
- A command is driven for exactly one cycle. Every other cycle with `cs_n`=0 is NOP, with `ba`/`addr` returned to 0.
- States and transitions:
  - WAIT_LOCK: idle outputs. Go to WAIT_PWR when `ok_s`=1, loading counter = POWERUP_CYCLES-1.
  - WAIT_PWR: `cke`=0, `cs_n`=1. Count down; at 0, go to CKE_UP.
  - CKE_UP: `cke`=1, `cs_n`=0, NOP. Lasts 2 cycles, then PRE1.
  - PRE1: PRECHARGE with `addr[10]`=1 (all banks). Gap TRP.
  - EMR: LOAD MODE with `ba`=01, `addr`=EMR_VALUE. Gap TMRD.
  - MR_DLL: LOAD MODE with `ba`=00, `addr`=MR_VALUE with bit 8 set. Gap TMRD.
  - PRE2: as PRE1. Gap TRP.
  - REF1: AUTO REFRESH. Gap TRFC.
  - REF2: AUTO REFRESH. Gap TRFC.
  - MR: LOAD MODE with `ba`=00, `addr`=MR_VALUE with bit 8 cleared. Gap DLL_LOCK_CYCLES.
  - DONE: `init_done`=1, `cke`=1, NOP held.
- "Gap N" means the next command, or the `init_done` rise, occurs exactly N cycles after the cycle in which the command was driven. The N-1 cycles in between are NOP.
- Every parameter gap must be ≥1. A gap of 1 means back-to-back commands.
- Counter width is `$clog2` of the largest count plus 1. It is never compared against a negative value.
- Loss of lock: `ok_s`=0 in any state other than WAIT_LOCK returns the block to WAIT_LOCK on the next edge, with all outputs at reset values (`init_done` drops). The full sequence restarts when lock returns.
- Reset asserted mid-sequence forces reset values immediately, because reset is asynchronous.

## Timing
- Lock to WAIT_PWR: `clk_ok` rising is seen in WAIT_PWR 3 edges later (2 synchronizer flops plus the state register).
- `cke` rises POWERUP_CYCLES cycles after WAIT_PWR is entered.
- With the cycle `cke` rises as t0, commands occur at:
  - PRE1 at t0+2
  - EMR at t0+2+TRP
  - MR_DLL at +TMRD after that
  - PRE2 at +TMRD after that
  - REF1 at +TRP after that
  - REF2 at +TRFC after that
  - MR at +TRFC after that
- `init_done` rises DLL_LOCK_CYCLES after MR.
- At defaults, MR occurs at t0+28 and `init_done` rises at t0+228.
- `init_done` is sticky until loss of lock or reset.

## Structure
- Package `ddr_pkg`:
  - command encodings (NOP, PRECHARGE, REFRESH, LOAD_MODE)
  - the sequencer state enum
  - the constant for the DLL-reset bit position (8)
  - the constant for the precharge-all bit position (10)
- One sub-module, `bit_synchronizer`: a 2-flop synchronizer with async active-low reset, used for `clk_ok`.

## Test plan
- Reset with `clk_ok`=1 throughout, defaults except POWERUP_CYCLES=16 → `cke` rises 19 cycles after reset release; commands appear at t0+2, 5, 7, 9, 12, 20, 28 with encodings 010, 000, 000, 010, 001, 001, 000; `init_done` rises at t0+228.
- Check LOAD MODE operands → EMR has `ba`=01, `addr`=0000; MR_DLL has `ba`=00, `addr`=0x0121; final MR has `addr`=0x0021; both PRECHARGE cycles have `addr[10]`=1.
- `clk_ok` held 0 for 1000 cycles → `cke`=0, `cs_n`=1, `init_done`=0 throughout.
- `clk_ok` dropped for 1 cycle at t0+10 → block returns to WAIT_LOCK, `cke`=0; after re-lock the full sequence repeats with identical spacing.
- `rst_n` asserted asynchronously, mid-cycle, between REF1 and REF2 → all outputs reach reset values before the next `clk` edge; the sequence restarts after release.
- TRP=TMRD=TRFC=1, DLL_LOCK_CYCLES=1 → commands on 7 consecutive cycles, `init_done` the following cycle.
